strand_load_sequencer: RTL and testbench

Controller that sequences the loading of a batch of DNA strands into the correlator. On a start pulse it latches the strand count and waits a fixed warm-up period. It then issues one load request per strand over a valid/ready handshake, limiting in-flight loads by a credit count. It drains all outstanding correlator results, then pulses done. It replaces free-running load-enable generation with an explicit, abortable, back-pressure-aware schedule.

---
 rtl/strand_load_sequencer.sv | 146 ++++++++++++++
 tb/tb_strand_load_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strand_load_sequencer.sv
// Strand load sequencer: warm-up, credit-limited load requests, result drain.
// Abortable batch controller feeding the correlator over a valid/ready handshake.
module strand_load_sequencer #(
    parameter int WARMUP_CYCLES   = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDX_W           = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [IDX_W-1:0]                     num_of_strands,
    output logic                                 load_valid,
    output logic [IDX_W-1:0]                     load_idx,
    input  logic                                 cor_ready,
    input  logic                                 res_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err_zero,
    output logic                                 proto_err
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int WW = $clog2(WARMUP_CYCLES + 2);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WARM_LAST =
        WW'((WARMUP_CYCLES > 0) ? (WARMUP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OW-1:0]    out_q, out_d;
    logic [WW-1:0]    warm_q, warm_d;
    logic             err_zero_q, err_zero_d;
    logic             proto_err_q, proto_err_d;
    logic             xfer;
    logic             stray_res;

    always_comb begin
        load_valid  = (state_q == S_LOAD) && (out_q < MAX_O);
        xfer        = load_valid && cor_ready;
        stray_res   = res_valid && (out_q == '0) && !xfer;
        load_idx    = idx_q;
        outstanding = out_q;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        err_zero    = err_zero_q;
        proto_err   = proto_err_q;
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        out_d       = out_q;
        warm_d      = warm_q;
        err_zero_d  = 1'b0;
        proto_err_d = proto_err_q | stray_res;

        // A result paired with a same-cycle transfer nets to zero.
        if (xfer && !res_valid) begin
            out_d = out_q + OW'(1);
        end else if (!xfer && res_valid && (out_q != '0)) begin
            out_d = out_q - OW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_of_strands != '0) begin
                        n_d         = num_of_strands;
                        idx_d       = '0;
                        warm_d      = '0;
                        proto_err_d = 1'b0;
                        state_d     = (WARMUP_CYCLES == 0) ? S_LOAD : S_WARMUP;
                    end else begin
                        err_zero_d = 1'b1;
                    end
                end
            end
            S_WARMUP: begin
                if (warm_q == WARM_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    warm_d = warm_q + WW'(1);
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == n_q - IDX_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            out_d   = '0;
            warm_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            warm_q      <= '0;
            err_zero_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            warm_q      <= warm_d;
            err_zero_q  <= err_zero_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_strand_load_sequencer.sv
// Bench for strand_load_sequencer: load-index scoreboard plus directed checks.
// Inputs change 1 ns after posedge; the monitor samples on negedge.
module tb_strand_load_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] num_of_strands = '0;
    logic        load_valid;
    logic [31:0] load_idx;
    logic        cor_ready = 1'b0;
    logic        res_valid;
    logic [2:0]  outstanding;
    logic        busy;
    logic        done;
    logic        err_zero;
    logic        proto_err;

    logic        auto_res = 1'b0;
    logic        auto_rv = 1'b0;
    logic        man_res = 1'b0;
    logic        xfer_seen = 1'b0;
    logic        d1 = 1'b0;
    logic        d2 = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    int          xfers = 0;
    logic [31:0] exp_q[$];

    assign res_valid = auto_res ? auto_rv : man_res;

    always #5 clk = ~clk;

    strand_load_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .num_of_strands(num_of_strands),
        .load_valid(load_valid),
        .load_idx(load_idx),
        .cor_ready(cor_ready),
        .res_valid(res_valid),
        .outstanding(outstanding),
        .busy(busy),
        .done(done),
        .err_zero(err_zero),
        .proto_err(proto_err)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every transfer pops the next expected index.
    always @(negedge clk) begin
        xfer_seen = load_valid && cor_ready;
        if (xfer_seen) begin
            xfers++;
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {32'd0, load_idx}, 64'hFFFF_FFFF);
            end else begin
                chk("load_idx_sb", {32'd0, load_idx}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // Responder: one result two cycles after each transfer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_res) begin
                auto_rv = d2;
                d2 = d1;
                d1 = xfer_seen;
            end else begin
                auto_rv = 1'b0;
                d2 = 1'b0;
                d1 = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_batch(input logic [31:0] n);
        for (int i = 0; i < int'(n); i++) exp_q.push_back(32'(i));
        xfers = 0;
        num_of_strands = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_lv(input int limit);
        int c = 0;
        while (!load_valid && c < limit) begin
            step();
            c++;
        end
        chk("wait_load_valid", {63'd0, load_valid}, 64'd1);
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (done) nd++;
        end
    endtask

    initial begin
        int c;
        int nd;

        // Reset values
        step();
        step();
        chk("rst_load_valid", {63'd0, load_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_outstanding", {61'd0, outstanding}, 64'd0);
        chk("rst_load_idx", {32'd0, load_idx}, 64'd0);
        chk("rst_errs", {62'd0, err_zero, proto_err}, 64'd0);
        rst_n = 1'b1;
        step();

        // Basic batch N=3
        auto_res = 1'b1;
        cor_ready = 1'b1;
        begin_batch(32'd3);
        c = 1;
        while (!load_valid && c < 20) begin
            step();
            c++;
        end
        chk("first_lv_latency", 64'(c), 64'd6);
        chk("basic_idx0", {31'd0, load_valid, load_idx}, {31'd0, 1'b1, 32'd0});
        step();
        chk("basic_idx1", {31'd0, load_valid, load_idx}, {31'd0, 1'b1, 32'd1});
        step();
        chk("basic_idx2", {31'd0, load_valid, load_idx}, {31'd0, 1'b1, 32'd2});
        step();
        chk("basic_drain_lv", {63'd0, load_valid}, 64'd0);
        chk("basic_drain_idx", {32'd0, load_idx}, 64'd3);
        count_done(20, nd);
        chk("basic_done_pulses", 64'(nd), 64'd1);
        chk("basic_busy_after", {63'd0, busy}, 64'd0);
        chk("basic_xfers", 64'(xfers), 64'd3);
        chk("basic_sb_empty", 64'(exp_q.size()), 64'd0);

        // Back-pressure N=2
        cor_ready = 1'b0;
        begin_batch(32'd2);
        wait_lv(20);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold", {31'd0, load_valid, load_idx}, {31'd0, 1'b1, 32'd0});
            step();
        end
        chk("bp_no_xfer", 64'(xfers), 64'd0);
        cor_ready = 1'b1;
        count_done(20, nd);
        chk("bp_done", 64'(nd), 64'd1);
        chk("bp_xfers", 64'(xfers), 64'd2);

        // Credit limit N=8, no results
        auto_res = 1'b0;
        begin_batch(32'd8);
        wait_lv(20);
        for (int i = 0; i < 4; i++) step();
        chk("cr_xfers4", 64'(xfers), 64'd4);
        chk("cr_lv_blocked", {63'd0, load_valid}, 64'd0);
        chk("cr_out4", {61'd0, outstanding}, 64'd4);
        step();
        chk("cr_still_blocked", {61'd0, outstanding, 1'b0, load_valid}, {61'd0, 3'd4, 2'd0} >> 2 << 2 | 64'd16);
        man_res = 1'b1;
        step();
        chk("cr_res_out3", {61'd0, outstanding}, 64'd3);
        chk("cr_res_lv", {63'd0, load_valid}, 64'd1);
        step();
        chk("cr_both_out3", {61'd0, outstanding}, 64'd3);
        chk("cr_both_xfers", 64'(xfers), 64'd5);
        man_res = 1'b0;
        step();
        chk("cr_one_more_out4", {61'd0, outstanding}, 64'd4);
        chk("cr_one_more_xfers", 64'(xfers), 64'd6);
        chk("cr_one_more_lv", {63'd0, load_valid}, 64'd0);
        nd = 0;
        for (int i = 0; i < 30 && nd == 0; i++) begin
            man_res = (outstanding != 3'd0);
            step();
            if (done) nd++;
        end
        man_res = 1'b0;
        chk("cr_done", 64'(nd), 64'd1);
        chk("cr_xfers8", 64'(xfers), 64'd8);
        chk("cr_no_proto", {63'd0, proto_err}, 64'd0);
        step();

        // Zero count, then start ignored while busy
        num_of_strands = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_err_pulse", {62'd0, err_zero, busy}, {62'd0, 2'b10});
        step();
        chk("zero_err_clear", {62'd0, err_zero, busy}, 64'd0);
        auto_res = 1'b1;
        begin_batch(32'd4);
        wait_lv(20);
        step();
        num_of_strands = 32'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_start_idx", {32'd0, load_idx}, 64'd2);
        count_done(20, nd);
        chk("ign_done", 64'(nd), 64'd1);
        chk("ign_xfers", 64'(xfers), 64'd4);
        chk("ign_sb_empty", 64'(exp_q.size()), 64'd0);

        // Abort at load_idx 2
        auto_res = 1'b0;
        begin_batch(32'd6);
        wait_lv(20);
        step();
        step();
        chk("ab_idx2", {32'd0, load_idx}, 64'd2);
        cor_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_q.delete();
        chk("ab_state", {62'd0, busy, load_valid}, 64'd0);
        chk("ab_cleared", {29'd0, outstanding, load_idx}, 64'd0);
        chk("ab_xfers", 64'(xfers), 64'd2);
        count_done(3, nd);
        chk("ab_no_done", 64'(nd), 64'd0);
        man_res = 1'b1;
        step();
        man_res = 1'b0;
        chk("ab_proto_set", {63'd0, proto_err}, 64'd1);
        step();
        chk("ab_proto_sticky", {63'd0, proto_err}, 64'd1);
        cor_ready = 1'b1;
        auto_res = 1'b1;
        begin_batch(32'd1);
        chk("ab_proto_clr", {63'd0, proto_err}, 64'd0);
        count_done(20, nd);
        chk("ab_next_done", 64'(nd), 64'd1);

        // Async reset in DRAIN
        auto_res = 1'b0;
        begin_batch(32'd2);
        wait_lv(20);
        step();
        step();
        chk("rs_in_drain", {60'd0, busy, load_valid, outstanding[1:0]},
            {60'd0, 4'b1010});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async_outs", {57'd0, load_valid, busy, done, err_zero,
                              proto_err, outstanding[1:0]}, 64'd0);
        chk("rs_async_idx", {32'd0, load_idx}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        auto_res = 1'b1;
        begin_batch(32'd1);
        count_done(20, nd);
        chk("rs_fresh_done", 64'(nd), 64'd1);
        chk("rs_fresh_xfers", 64'(xfers), 64'd1);
        chk("rs_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
